// File: rtl/video_timing_pkg.sv
// Shared types for the video timing generator: per-axis phase encoding and
// the default timing-field width.
package video_timing_pkg;

  localparam int CW_DEFAULT = 12;

  typedef enum logic [1:0] {
    ACTIVE = 2'd0,
    FP     = 2'd1,
    SYNC   = 2'd2,
    BP     = 2'd3
  } phase_t;

endpackage

// File: rtl/video_timing_axis.sv
// One timing axis: phase FSM ACTIVE -> FP -> SYNC -> BP plus a position
// counter that wraps at the end of the last non-empty phase.
module video_timing_axis
  import video_timing_pkg::*;
#(
  parameter int CW = CW_DEFAULT
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          step,
  input  logic [CW-1:0] act_len,
  input  logic [CW-1:0] fp_len,
  input  logic [CW-1:0] sync_len,
  input  logic [CW-1:0] bp_len,
  output phase_t        phase,
  output logic [CW-1:0] count,
  output logic          wrap
);

  logic [CW-1:0] act_end, fp_end, sync_end, last, count_next;
  phase_t        phase_next, after_active, after_fp;

  // Phase boundaries as absolute positions; a zero-length active phase
  // still occupies one position so the axis can never stall.
  always_comb begin
    act_end  = (act_len == '0) ? CW'(1) : act_len;
    fp_end   = act_end + fp_len;
    sync_end = fp_end + sync_len;
    last     = sync_end + bp_len - CW'(1);
  end

  assign wrap         = step && (count == last);
  assign after_active = (fp_len != '0) ? FP : (sync_len != '0) ? SYNC : BP;
  assign after_fp     = (sync_len != '0) ? SYNC : BP;

  // NOTE: every always_comb output gets a default first, so paths that do
  // not assign it hold the current value instead of inferring a latch.
  always_comb begin
    count_next = count;
    phase_next = phase;
    if (step) begin
      count_next = wrap ? '0 : count + CW'(1);
      if (wrap) begin
        phase_next = ACTIVE;
      end else begin
        case (phase)
          ACTIVE: if (count_next == act_end)  phase_next = after_active;
          FP:     if (count_next == fp_end)   phase_next = after_fp;
          SYNC:   if (count_next == sync_end) phase_next = BP;
          BP:     phase_next = BP;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase <= ACTIVE;
      count <= '0;
    end else begin
      phase <= phase_next;
      count <= count_next;
    end
  end

endmodule

// File: rtl/video_timing_gen.sv
// Programmable video timing generator: pixel-clock divider, shadowed
// horizontal/vertical timing, sync, display-enable and frame-start outputs.
module video_timing_gen
  import video_timing_pkg::*;
#(
  parameter int CW = CW_DEFAULT
) (
  input  logic          CLK_VIDEO,
  input  logic          RESET_N,
  input  logic [3:0]    CE_DIV,
  input  logic [CW-1:0] H_ACT,
  input  logic [CW-1:0] H_FP,
  input  logic [CW-1:0] H_SYNC,
  input  logic [CW-1:0] H_BP,
  input  logic [CW-1:0] V_ACT,
  input  logic [CW-1:0] V_FP,
  input  logic [CW-1:0] V_SYNC,
  input  logic [CW-1:0] V_BP,
  input  logic [1:0]    SYNC_POL,
  output logic          CE_PIXEL,
  output logic          VGA_HS,
  output logic          VGA_VS,
  output logic          VGA_DE,
  output logic [CW-1:0] HCNT,
  output logic [CW-1:0] VCNT,
  output logic          FRAME_START
);

  typedef struct packed {
    logic [CW-1:0] act;
    logic [CW-1:0] fp;
    logic [CW-1:0] sync;
    logic [CW-1:0] bp;
  } axis_len_t;

  axis_len_t  h_in, v_in, h_shadow, v_shadow, h_len, v_len;
  logic       primed, running;
  logic [3:0] div_cnt, div_lim, div_lim_eff;
  logic       div_wrap, h_wrap, v_wrap;
  phase_t     h_phase, v_phase;

  assign h_in = {H_ACT, H_FP, H_SYNC, H_BP};
  assign v_in = {V_ACT, V_FP, V_SYNC, V_BP};

  // NOTE: shadow registers reset to a constant; until the first clock after
  // reset the live inputs are used instead, which behaves as if the shadows
  // were loaded from the inputs during reset.
  assign h_len       = primed ? h_shadow : h_in;
  assign v_len       = primed ? v_shadow : v_in;
  assign div_lim_eff = primed ? div_lim  : CE_DIV;
  assign div_wrap    = (div_cnt == div_lim_eff);

  always_ff @(posedge CLK_VIDEO or negedge RESET_N) begin
    if (!RESET_N) begin
      primed   <= 1'b0;
      running  <= 1'b0;
      div_cnt  <= '0;
      div_lim  <= '0;
      CE_PIXEL <= 1'b0;
      h_shadow <= '0;
      v_shadow <= '0;
    end else begin
      primed   <= 1'b1;
      CE_PIXEL <= div_wrap;
      div_cnt  <= div_wrap ? '0 : div_cnt + 4'd1;
      if (div_wrap || !primed) div_lim <= CE_DIV;
      if (div_wrap) running <= 1'b1;
      // v_wrap is the last CE of the frame: new lengths apply from the next one.
      if (v_wrap || !primed) begin
        h_shadow <= h_in;
        v_shadow <= v_in;
      end
    end
  end

  video_timing_axis #(.CW(CW)) u_h_axis (
    .clk      (CLK_VIDEO),
    .rst_n    (RESET_N),
    .step     (CE_PIXEL),
    .act_len  (h_len.act),
    .fp_len   (h_len.fp),
    .sync_len (h_len.sync),
    .bp_len   (h_len.bp),
    .phase    (h_phase),
    .count    (HCNT),
    .wrap     (h_wrap)
  );

  video_timing_axis #(.CW(CW)) u_v_axis (
    .clk      (CLK_VIDEO),
    .rst_n    (RESET_N),
    .step     (h_wrap),
    .act_len  (v_len.act),
    .fp_len   (v_len.fp),
    .sync_len (v_len.sync),
    .bp_len   (v_len.bp),
    .phase    (v_phase),
    .count    (VCNT),
    .wrap     (v_wrap)
  );

  // running keeps DE and FRAME_START low until the first pixel strobe.
  assign VGA_DE      = running && (h_phase == ACTIVE) && (v_phase == ACTIVE);
  assign FRAME_START = running && (HCNT == '0) && (VCNT == '0);
  assign VGA_HS      = (h_phase == SYNC) ~^ SYNC_POL[0];
  assign VGA_VS      = (v_phase == SYNC) ~^ SYNC_POL[1];

endmodule

// File: tb/tb_video_timing_gen.sv
// Self-checking bench for video_timing_gen: table-driven timing configs plus
// directed shadow-register and asynchronous-reset sequences.
module tb_video_timing_gen;

  localparam int CW = 12;

  logic          clk;
  logic          RESET_N;
  logic [3:0]    CE_DIV;
  logic [CW-1:0] H_ACT, H_FP, H_SYNC, H_BP;
  logic [CW-1:0] V_ACT, V_FP, V_SYNC, V_BP;
  logic [1:0]    SYNC_POL;
  logic          CE_PIXEL, VGA_HS, VGA_VS, VGA_DE, FRAME_START;
  logic [CW-1:0] HCNT, VCNT;

  int n_checks = 0;
  int n_pass   = 0;

  video_timing_gen #(.CW(CW)) dut (
    .CLK_VIDEO   (clk),
    .RESET_N     (RESET_N),
    .CE_DIV      (CE_DIV),
    .H_ACT       (H_ACT),
    .H_FP        (H_FP),
    .H_SYNC      (H_SYNC),
    .H_BP        (H_BP),
    .V_ACT       (V_ACT),
    .V_FP        (V_FP),
    .V_SYNC      (V_SYNC),
    .V_BP        (V_BP),
    .SYNC_POL    (SYNC_POL),
    .CE_PIXEL    (CE_PIXEL),
    .VGA_HS      (VGA_HS),
    .VGA_VS      (VGA_VS),
    .VGA_DE      (VGA_DE),
    .HCNT        (HCNT),
    .VCNT        (VCNT),
    .FRAME_START (FRAME_START)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [3:0] ce_div;
    int         h_act, h_fp, h_sync, h_bp;
    int         v_act, v_fp, v_sync, v_bp;
    logic [1:0] pol;
    int         exp_htotal, exp_vtotal;
    int         exp_hact, exp_vact;
    int         exp_hs_start, exp_vs_start;
  } vec_t;

  vec_t vecs[4];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic apply(input vec_t v);
    CE_DIV   = v.ce_div;
    H_ACT    = CW'(v.h_act);
    H_FP     = CW'(v.h_fp);
    H_SYNC   = CW'(v.h_sync);
    H_BP     = CW'(v.h_bp);
    V_ACT    = CW'(v.v_act);
    V_FP     = CW'(v.v_fp);
    V_SYNC   = CW'(v.v_sync);
    V_BP     = CW'(v.v_bp);
    SYNC_POL = v.pol;
  endtask

  // Release reset at a negedge and return the clocks until the first CE.
  task automatic release_and_wait_ce(output int lat);
    RESET_N = 1'b1;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!CE_PIXEL && lat < 64);
  endtask

  task automatic run_vector(input int idx, input vec_t v);
    int lat, clocks, ces, des, model_err, stab_err, vs_err, gap_err, eh, ev, since_ce;
    bit done;
    logic [CW-1:0] p_h, p_v;
    logic p_de, p_hs, p_vs, p_fs, p_ce, p_vs_ce, exp_de, exp_hs, exp_vs;

    RESET_N = 1'b0;
    apply(v);
    repeat (3) @(negedge clk);
    check($sformatf("v%0d_reset_outputs", idx),
          {CE_PIXEL, VGA_DE, FRAME_START, HCNT, VCNT}, '0);
    check($sformatf("v%0d_reset_sync_levels", idx), {VGA_HS, VGA_VS}, {~v.pol[0], ~v.pol[1]});

    release_and_wait_ce(lat);
    check($sformatf("v%0d_first_ce_latency", idx), lat, v.ce_div + 1);
    check($sformatf("v%0d_first_pixel_hv_fs_de", idx),
          {HCNT, VCNT, FRAME_START, VGA_DE}, {CW'(0), CW'(0), 1'b1, 1'b1});

    eh = 0; ev = 0; clocks = 0; ces = 0; des = 0;
    model_err = 0; stab_err = 0; vs_err = 0; gap_err = 0; since_ce = 0;
    done = 1'b0; p_ce = 1'b1; p_vs_ce = 1'b0;
    p_h = '0; p_v = '0; p_de = 1'b0; p_hs = 1'b0; p_vs = 1'b0; p_fs = 1'b0;
    for (int c = 0; c < 4000; c++) begin
      if (c > 0 && !p_ce &&
          {HCNT, VCNT, VGA_DE, VGA_HS, VGA_VS, FRAME_START} !== {p_h, p_v, p_de, p_hs, p_vs, p_fs})
        stab_err++;
      if (CE_PIXEL) begin
        if (c > 0 && since_ce != v.ce_div + 1) gap_err++;
        since_ce = 0;
        if (c > 0 && eh == 0 && ev == 0) begin
          done = 1'b1;
          break;
        end
        exp_de = (eh < v.exp_hact) && (ev < v.exp_vact);
        exp_hs = (eh >= v.exp_hs_start && eh < v.exp_hs_start + v.h_sync) ? v.pol[0] : ~v.pol[0];
        exp_vs = (ev >= v.exp_vs_start && ev < v.exp_vs_start + v.v_sync) ? v.pol[1] : ~v.pol[1];
        if (HCNT !== CW'(eh) || VCNT !== CW'(ev) || VGA_DE !== exp_de || VGA_HS !== exp_hs ||
            VGA_VS !== exp_vs || FRAME_START !== (eh == 0 && ev == 0))
          model_err++;
        if (ces > 0 && VGA_VS !== p_vs_ce && HCNT != '0) vs_err++;
        p_vs_ce = VGA_VS;
        des += int'(VGA_DE);
        ces++;
        eh++;
        if (eh == v.exp_htotal) begin
          eh = 0;
          ev++;
          if (ev == v.exp_vtotal) ev = 0;
        end
      end
      p_h = HCNT; p_v = VCNT; p_de = VGA_DE; p_hs = VGA_HS; p_vs = VGA_VS; p_fs = FRAME_START;
      p_ce = CE_PIXEL;
      @(negedge clk);
      clocks++;
      since_ce++;
    end
    check($sformatf("v%0d_frame_completed", idx), done, 1'b1);
    check($sformatf("v%0d_next_frame_start", idx), FRAME_START, 1'b1);
    check($sformatf("v%0d_frame_clocks", idx), clocks,
          v.exp_htotal * v.exp_vtotal * (v.ce_div + 1));
    check($sformatf("v%0d_ces_per_frame", idx), ces, v.exp_htotal * v.exp_vtotal);
    check($sformatf("v%0d_de_per_frame", idx), des, v.exp_hact * v.exp_vact);
    check($sformatf("v%0d_model_errors", idx), model_err, 0);
    check($sformatf("v%0d_stability_errors", idx), stab_err, 0);
    check($sformatf("v%0d_ce_gap_errors", idx), gap_err, 0);
    check($sformatf("v%0d_vs_edge_off_line_start", idx), vs_err, 0);
  endtask

  // Runs from a frame-start CE to the next one; optionally reprograms
  // H_ACT mid-frame to exercise the shadow registers.
  task automatic measure_frame(input bit do_change, input int new_hact,
                               output bit done, output int ces, output int des, output int maxh);
    done = 1'b0; ces = 0; des = 0; maxh = 0;
    for (int c = 0; c < 4000; c++) begin
      if (CE_PIXEL) begin
        if (c > 0 && FRAME_START) begin
          done = 1'b1;
          break;
        end
        ces++;
        des += int'(VGA_DE);
        if (int'(HCNT) > maxh) maxh = int'(HCNT);
        if (do_change && VCNT == CW'(2) && HCNT == CW'(4)) H_ACT = CW'(new_hact);
      end
      @(negedge clk);
    end
  endtask

  initial begin
    int  lat, ces, des, maxh;
    bit  done, found;
    vec_t v;

    //          ce_div  H act fp sy bp   V act fp sy bp  pol    Ht Vt Ha Va Hs Vs
    vecs[0] = '{4'd3,   8, 2, 3, 2,      4, 1, 2, 1,     2'b00, 15, 8, 8, 4, 10, 5};
    vecs[1] = '{4'd0,   8, 2, 3, 2,      4, 1, 2, 1,     2'b11, 15, 8, 8, 4, 10, 5};
    vecs[2] = '{4'd1,   8, 0, 3, 2,      4, 1, 2, 0,     2'b10, 13, 7, 8, 4,  8, 5};
    vecs[3] = '{4'd2,   0, 2, 1, 1,      3, 0, 1, 0,     2'b01,  5, 4, 1, 3,  3, 3};

    RESET_N = 1'b0;
    apply(vecs[0]);
    repeat (2) @(negedge clk);

    for (int i = 0; i < 4; i++) run_vector(i, vecs[i]);

    // Mid-frame H_ACT change: current frame keeps 15-pixel lines, next has 12.
    v = vecs[0];
    v.ce_div = 4'd0;
    RESET_N = 1'b0;
    apply(v);
    repeat (2) @(negedge clk);
    release_and_wait_ce(lat);
    check("shadow_first_ce_latency", lat, 1);
    measure_frame(1'b1, 5, done, ces, des, maxh);
    check("shadow_cur_frame_done", done, 1'b1);
    check("shadow_cur_frame_ces", ces, 120);
    check("shadow_cur_frame_htotal", maxh + 1, 15);
    check("shadow_cur_frame_de", des, 32);
    measure_frame(1'b0, 0, done, ces, des, maxh);
    check("shadow_next_frame_done", done, 1'b1);
    check("shadow_next_frame_ces", ces, 96);
    check("shadow_next_frame_htotal", maxh + 1, 12);
    check("shadow_next_frame_de", des, 20);

    // Asynchronous reset mid-line while HS and VS are both active.
    RESET_N = 1'b0;
    apply(vecs[0]);
    repeat (2) @(negedge clk);
    release_and_wait_ce(lat);
    found = 1'b0;
    for (int c = 0; c < 2000; c++) begin
      if (CE_PIXEL && VCNT == CW'(5) && HCNT == CW'(11)) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check("areset_target_reached", found, 1'b1);
    check("areset_pre_sync_active", {VGA_HS, VGA_VS}, 2'b00);
    #2 RESET_N = 1'b0;
    #1;
    check("areset_outputs_async", {CE_PIXEL, VGA_DE, FRAME_START, HCNT, VCNT}, '0);
    check("areset_sync_inactive", {VGA_HS, VGA_VS}, 2'b11);
    SYNC_POL = 2'b11;
    #1;
    check("sync_pol_immediate", {VGA_HS, VGA_VS}, 2'b00);
    SYNC_POL = 2'b00;
    repeat (2) @(negedge clk);
    release_and_wait_ce(lat);
    check("areset_release_latency", lat, 4);
    check("areset_first_pixel", {HCNT, VCNT, FRAME_START, VGA_DE}, {CW'(0), CW'(0), 1'b1, 1'b1});

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/video_timing_gen.md
VIDEO_TIMING_GEN -- requirements
Module: video_timing_gen

Interface
REQ-001 Parameter CW, default 12: width of every timing field and counter.
REQ-002 CLK_VIDEO  in  1: video clock; the only clock in the block.
REQ-003 RESET_N  in  1: reset, asynchronous assert, active-low.
REQ-004 CE_DIV  in  4: pixel divider; one CE_PIXEL pulse every CE_DIV+1 clocks.
REQ-005 H_ACT, H_FP, H_SYNC, H_BP  in  CW each: horizontal active, front porch, sync and back porch lengths, in pixels.
REQ-006 V_ACT, V_FP, V_SYNC, V_BP  in  CW each: vertical active, front porch, sync and back porch lengths, in lines.
REQ-007 SYNC_POL  in  2: bit0 = HS active-high, bit1 = VS active-high.
REQ-008 CE_PIXEL  out  1: registered pixel strobe.
REQ-009 VGA_HS, VGA_VS, VGA_DE  out  1 each: sync and display-enable outputs.
REQ-010 HCNT, VCNT  out  CW each: pixel and line position, both 0 at the first active pixel/line.
REQ-011 FRAME_START  out  1: one-CE pulse on the first active pixel of a frame.

Function
REQ-012 A divider counter SHALL assert CE_PIXEL for exactly 1 clock every CE_DIV+1 clocks; CE_DIV=0 SHALL give CE_PIXEL held high.
REQ-013 Every other output SHALL change only on the clock edge where CE_PIXEL is high; values SHALL be stable for the entire pixel period.
REQ-014 Each axis SHALL run the FSM ACTIVE -> FP -> SYNC -> BP -> ACTIVE; the horizontal axis advances per CE, the vertical axis advances on the CE that ends H_BP.
REQ-015 A phase programmed to length 0 SHALL be skipped in zero cycles; ACT=0 SHALL be treated as 1.
REQ-016 HCNT SHALL count 0..Htotal-1 and wrap at the end of H_BP, where Htotal = H_ACT+H_FP+H_SYNC+H_BP. VCNT SHALL do the same over Vtotal.
REQ-017 VGA_DE SHALL equal (h==ACTIVE)&(v==ACTIVE).
REQ-018 VGA_HS SHALL be active during h==SYNC, and VGA_VS during v==SYNC, at the polarity given by SYNC_POL.
REQ-019 VS edges SHALL coincide with the line boundary, i.e. HCNT==0.
REQ-020 All eight length inputs SHALL be shadow-registered on the last CE of a frame; changes made mid-frame SHALL take effect on the next frame only.
REQ-021 CE_DIV SHALL be sampled when the divider wraps.
REQ-022 SYNC_POL SHALL apply immediately.
REQ-023 Phase length arithmetic SHALL be CW bits wide; totals exceeding 2^CW-1 are unsupported.

Reset
REQ-024 During reset: CE_PIXEL=0, VGA_DE=0, FRAME_START=0, HCNT=0, VCNT=0, both FSMs in ACTIVE, HS/VS at inactive level per SYNC_POL, shadow registers loaded from the inputs.
REQ-025 After RESET_N deasserts, the first CE_PIXEL SHALL occur CE_DIV+1 clocks later and SHALL carry pixel (0,0) with FRAME_START=1.
REQ-026 Reset asserted mid-line or mid-frame SHALL immediately force the REQ-024 state, with no partial line emitted.

Structure
REQ-027 Package video_timing_pkg SHALL hold the phase enum (ACTIVE, FP, SYNC, BP) and the default CW.
REQ-028 Sub-module video_timing_axis (a phase FSM plus counter, with inputs step/lengths and outputs phase/count/wrap) SHALL be instantiated twice: horizontal stepped by CE, vertical stepped by horizontal wrap.

Verification
REQ-029 H=320/16/32/32, V=240/4/3/15, CE_DIV=3 -> CE every 4 clocks; 320 DE CEs per line; 240 DE lines per frame; FRAME_START period 419200 clocks.
REQ-030 Same setup with SYNC_POL=0 -> HS low for 32 CEs starting at HCNT=336; VS low for 3 lines starting at VCNT=244 with HCNT=0.
REQ-031 H_FP=0, V_BP=0 -> SYNC starts at HCNT=320; Vtotal=247; no glitch or extra CE on the skipped phases.
REQ-032 Change H_ACT to 256 at VCNT=100 -> the current frame keeps 320-pixel lines; the next frame has 256-pixel lines and Htotal=336.
REQ-033 Assert RESET_N low at HCNT=150, VCNT=77 -> outputs take reset values asynchronously; after release the first CE yields HCNT=0, VCNT=0, FRAME_START=1.
REQ-034 CE_DIV=0 -> CE_PIXEL constantly 1; frame period equals Htotal*Vtotal clocks.
